// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 1250;
    localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module rx_sync (
    input  logic clk,
    input  logic nRst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit, presents a byte with a one-cycle ready
// strobe and flags frames whose stop bit reads low.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      nRst,
    input  logic                      rx_serial,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      rx_ready,
    output logic                      frame_err,
    output logic                      rx_busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int BIT_W    = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] IDX_LAST = BIT_W'(UART_DATA_BITS - 1);

    logic                      w_rx_s;
    rx_state_t                 r_state;
    logic [CNT_W-1:0]          r_clk_cnt;
    logic [BIT_W-1:0]          r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_byte;
    logic                      r_ready;
    logic                      r_err;
    logic                      r_busy;

    rx_sync u_sync (
        .clk  (clk),
        .nRst (nRst),
        .d    (rx_serial),
        .q    (w_rx_s)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_byte    <= '0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_clk_cnt == CNT_HALF) begin
                        r_clk_cnt <= '0;
                        // A start bit that is high again at its centre was only a glitch.
                        if (!w_rx_s) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_clk_cnt == CNT_BIT) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                        if (r_bit_idx == IDX_LAST) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_clk_cnt == CNT_BIT) begin
                        r_clk_cnt <= '0;
                        r_state   <= CLEANUP;
                        if (w_rx_s) begin
                            r_byte  <= r_shift;
                            r_ready <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                CLEANUP: begin
                    // Waiting for a high line keeps a break from posing as a new start bit.
                    r_clk_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_clk_cnt <= '0;
                    r_bit_idx <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign rx_byte   = r_byte;
    assign rx_ready  = r_ready;
    assign frame_err = r_err;
    assign rx_busy   = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: per-cycle expectation tables filled
// from frame timing arithmetic, checked every cycle, plus literal spot checks.
module tb_uart_rx;

    localparam int C    = 16;
    localparam int H    = C / 2;
    localparam int SYNC = 3;        // pin change to FSM reaction, in clock edges
    localparam int MAXC = 4096;

    logic       clk;
    logic       nRst;
    logic       rx_serial;
    logic [7:0] rx_byte;
    logic       rx_ready;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit         exp_ready [MAXC];
    bit         exp_err   [MAXC];
    bit         exp_busy  [MAXC];
    logic [7:0] exp_val   [MAXC];
    logic [7:0] mbyte = 8'h00;
    int         ready_cycs[$];
    int         err_cnt = 0;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .rx_serial (rx_serial),
        .rx_byte   (rx_byte),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mark_busy(input int a, input int b);
        for (int n = a; n <= b; n++)
            if (n < MAXC) exp_busy[n] = 1'b1;
    endtask

    // Drives one frame starting now; a low stop level lasts low_len cycles before release.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int low_len);
        int p, q, r;
        p = cyc;
        q = p + SYNC + H + 9 * C;
        if (stop) begin
            mark_busy(p + SYNC, q);
            exp_ready[q] = 1'b1;
            exp_val[q]   = d;
        end else begin
            r = p + 9 * C + low_len;
            mark_busy(p + SYNC, (r + 2 > q) ? r + 2 : q);
            exp_err[q] = 1'b1;
        end
        rx_serial = 1'b0;
        tick(C);
        for (int k = 0; k < 8; k++) begin
            rx_serial = d[k];
            tick(C);
        end
        rx_serial = stop;
        if (stop) begin
            tick(C);
        end else begin
            tick(low_len);
            rx_serial = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (!nRst) begin
            mbyte = 8'h00;
            chk("rst_byte", rx_byte, 0);
            chk("rst_ready", rx_ready, 0);
            chk("rst_err", frame_err, 0);
            chk("rst_busy", rx_busy, 0);
        end else if (cyc < MAXC) begin
            if (exp_ready[cyc]) mbyte = exp_val[cyc];
            chk("ready", rx_ready, exp_ready[cyc]);
            chk("frame_err", frame_err, exp_err[cyc]);
            chk("busy", rx_busy, exp_busy[cyc]);
            chk("byte", rx_byte, mbyte);
            if (rx_ready) ready_cycs.push_back(cyc);
            if (frame_err) err_cnt++;
        end
    end

    initial begin
        int p;
        nRst      = 1'b0;
        rx_serial = 1'b1;
        tick(3);
        nRst = 1'b1;
        tick(5);

        // Single frame 'A'
        p = cyc;
        send_frame(8'h41, 1'b1, 0);
        tick(10);
        chk("t1_nready", ready_cycs.size(), 1);
        if (ready_cycs.size() > 0) chk("t1_ready_cycle", ready_cycs[0] - p, 155);
        chk("t1_byte", rx_byte, 8'h41);
        chk("t1_busy", rx_busy, 0);

        // Back-to-back frames, no idle gap
        p = cyc;
        send_frame(8'h48, 1'b1, 0);
        send_frame(8'h4E, 1'b1, 0);
        tick(10);
        chk("t2_nready", ready_cycs.size(), 3);
        if (ready_cycs.size() >= 3) begin
            chk("t2_first", ready_cycs[1] - p, 155);
            chk("t2_spacing", ready_cycs[2] - ready_cycs[1], 160);
        end
        chk("t2_byte", rx_byte, 8'h4E);

        // Glitch of 3 cycles
        p = cyc;
        mark_busy(p + SYNC, p + SYNC + H - 1);
        rx_serial = 1'b0;
        tick(3);
        rx_serial = 1'b1;
        tick(30);
        chk("t3_nready", ready_cycs.size(), 3);
        chk("t3_nerr", err_cnt, 0);
        chk("t3_byte", rx_byte, 8'h4E);

        // Framing error on 0x55
        send_frame(8'h55, 1'b0, C);
        tick(10);
        chk("t4_nerr", err_cnt, 1);
        chk("t4_nready", ready_cycs.size(), 3);
        chk("t4_byte", rx_byte, 8'h4E);

        // Break: 30 bit times low, then a good frame
        send_frame(8'h00, 1'b0, 30 * C - 9 * C);
        tick(10);
        chk("t5_nerr", err_cnt, 2);
        send_frame(8'h5A, 1'b1, 0);
        tick(10);
        chk("t5_byte", rx_byte, 8'h5A);
        chk("t5_nready", ready_cycs.size(), 4);

        // Reset during bit 4 of 0xC3
        p = cyc;
        mark_busy(p + SYNC, p + 5 * C + H - 1);
        rx_serial = 1'b0;
        tick(C);
        for (int k = 0; k < 4; k++) begin
            rx_serial = 8'hC3 >> k;
            tick(C);
        end
        rx_serial = 1'b0;
        tick(H);
        nRst      = 1'b0;
        rx_serial = 1'b1;
        @(negedge clk);
        chk("t6_rst_byte", rx_byte, 0);
        chk("t6_rst_busy", rx_busy, 0);
        tick(3);
        nRst = 1'b1;
        tick(20);
        chk("t6_nready", ready_cycs.size(), 4);
        send_frame(8'h3C, 1'b1, 0);
        tick(20);
        chk("t6_byte", rx_byte, 8'h3C);
        chk("t6_nready_after", ready_cycs.size(), 5);
        chk("t6_nerr", err_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive front end of the wireless Hangman link. It is the opposite end of the byte-level UART path that the message register feeds on the transmit side.
- Samples the asynchronous rx_serial line as 8N1, LSB first, idle high.
- Assembles one byte per frame and presents it to game logic as a registered byte with a one-cycle rx_ready strobe.
- Flags frames whose stop bit is low.

Parameters:
CLKS_PER_BIT, 1250, system clocks per UART bit (12 MHz / 9600 baud); legal range >= 4
HALF_BIT, CLKS_PER_BIT/2, derived (localparam), clocks from detected start edge to start-bit centre

Ports:
clk  input  1  system clock, all logic on rising edge
nRst  input  1  asynchronous active-low reset
rx_serial  input  1  raw asynchronous serial line, idle high
rx_byte  output  8  last correctly framed byte; holds until the next good frame
rx_ready  output  1  one-cycle pulse: rx_byte was just updated
frame_err  output  1  one-cycle pulse: stop bit sampled low, frame discarded
rx_busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (asynchronous, nRst low):
  - state=IDLE, clk_cnt=0, bit_idx=0, shift=8'h00.
  - rx_byte=8'h00, rx_ready=0, frame_err=0, rx_busy=0.
  - Both synchronizer flops reset to 1.
  - Reset mid-frame abandons the frame with no rx_ready and no frame_err.
- Synchronizer: 2 flops, rx_serial to rx_s. The FSM sees only rx_s, which is 2 cycles behind the pin.
- Counter: clk_cnt is sized $clog2(CLKS_PER_BIT). It is cleared on every state change and at each bit sample.
- States:
  - IDLE: when rx_s==0 (cycle t0), go to START with clk_cnt=0.
  - START: when clk_cnt==HALF_BIT-1, sample rx_s.
    - If 0: go to DATA, clk_cnt=0, bit_idx=0.
    - If 1: false start, go to IDLE with no outputs.
  - DATA: when clk_cnt==CLKS_PER_BIT-1, shift is updated as shift <= {rx_s, shift[7:1]} (LSB first).
    - If bit_idx==7: go to STOP.
    - Else bit_idx++.
  - STOP: when clk_cnt==CLKS_PER_BIT-1, sample rx_s.
    - If 1: rx_byte<=shift and rx_ready<=1.
    - If 0: frame_err<=1 and rx_byte is unchanged.
    - Either way, go to CLEANUP.
  - CLEANUP: rx_ready and frame_err return to 0.
    - Go to IDLE only when rx_s==1.
    - A held-low (break) line stays in CLEANUP and does not start a new frame.
- Timing, with t0 = first IDLE cycle seeing rx_s==0:
  - Start-bit sample at t0+HALF_BIT.
  - Data bit k sample at t0+HALF_BIT+(k+1)*CLKS_PER_BIT.
  - Stop-bit sample at t0+HALF_BIT+9*CLKS_PER_BIT.
  - rx_ready/frame_err are high in exactly the following cycle.
- Pulses: rx_ready and frame_err are mutually exclusive and never high for more than one cycle.
- Back-to-back frames: a start edge arriving immediately after the stop bit is accepted. CLEANUP lasts 1 cycle when the line is high, so no frame is lost at the rated baud.
- Outputs: all outputs are registered and there are no combinational paths from rx_serial.
- Unreachable state encodings go to IDLE.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, CLEANUP}.
  - Constant DEFAULT_CLKS_PER_BIT = 1250.
  - Constant UART_DATA_BITS = 8.
- Sub-module rx_sync: 2-flop synchronizer, reset value 1, ports clk, nRst, d, q.
- Everything else stays in uart_rx.

Test Plan (bench uses CLKS_PER_BIT=16):
1. Single frame 8'h41 ('A') at exact baud -> one rx_ready pulse, rx_byte=8'h41, frame_err never high, rx_busy falls back to 0.
2. Back-to-back frames 8'h48, 8'h4E with no idle gap -> two rx_ready pulses exactly 10*16 cycles apart; rx_byte=8'h48, then 8'h4E.
3. Glitch: rx_serial low for 3 cycles, then high -> returns to IDLE, no rx_ready, no frame_err, rx_byte unchanged.
4. Framing error: send 8'h55 with stop bit low, then release the line -> frame_err pulses once, rx_ready stays 0, rx_byte keeps its previous value.
5. Break: hold rx_serial low for 30 bit times -> one frame_err, FSM parks in CLEANUP. After release, a following frame 8'h5A is received correctly.
6. Reset mid-frame: assert nRst during bit 4 of 8'hC3 -> all outputs reset immediately, no pulse. After reset release, the next frame 8'h3C is received correctly.
